// File: rtl/fwd_hazard_unit.sv
// Operand forwarding (M, W, retired-write history) and load-use stall control
// for the E stage of the five-stage pipeline.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned HIST_DEPTH = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_SRC*REG_AW-1:0]   SrcRegE,
  input  logic [NUM_SRC*DATA_W-1:0]   ReadSrcE,
  input  logic [NUM_SRC*REG_AW-1:0]   SrcRegD,
  input  logic [NUM_SRC-1:0]          SrcUsedD,
  input  logic                        RegWriteE,
  input  logic                        MemToRegE,
  input  logic [REG_AW-1:0]           WriteRegE,
  input  logic                        RegWriteM,
  input  logic [REG_AW-1:0]           WriteRegM,
  input  logic [DATA_W-1:0]           ALUOutM,
  input  logic                        RegWriteW,
  input  logic [REG_AW-1:0]           WriteRegW,
  input  logic [DATA_W-1:0]           ResultW,
  output logic [NUM_SRC*DATA_W-1:0]   SrcE,
  output logic [NUM_SRC*2-1:0]        FwdSel,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        FlushE,
  output logic [CNT_W-1:0]            StallCnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] regNum;
    logic [DATA_W-1:0] data;
  } histEntry_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  histEntry_t hist [HIST_DEPTH];
  state_t     state;
  state_t     stateNext;
  logic       loadUseHazard;

  // Retired-write history: shifts every cycle, stalls do not freeze it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int k = 0; k < int'(HIST_DEPTH); k++) begin
        hist[k] <= '0;
      end
    end else begin
      hist[0] <= '{valid:  RegWriteW && (WriteRegW != '0),
                   regNum: WriteRegW,
                   data:   ResultW};
      for (int k = 1; k < int'(HIST_DEPTH); k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  // Per-source forwarding, youngest producer wins
  always_comb begin
    SrcE   = '0;
    FwdSel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      SrcE[i*DATA_W +: DATA_W] = ReadSrcE[i*DATA_W +: DATA_W];
      FwdSel[i*2 +: 2]         = 2'b00;
      if (SrcRegE[i*REG_AW +: REG_AW] != '0) begin
        if (RegWriteM && (WriteRegM == SrcRegE[i*REG_AW +: REG_AW])) begin
          SrcE[i*DATA_W +: DATA_W] = ALUOutM;
          FwdSel[i*2 +: 2]         = 2'b01;
        end else if (RegWriteW && (WriteRegW == SrcRegE[i*REG_AW +: REG_AW])) begin
          SrcE[i*DATA_W +: DATA_W] = ResultW;
          FwdSel[i*2 +: 2]         = 2'b10;
        end else begin
          // Scan oldest to youngest so the lowest matching index is left standing
          for (int k = int'(HIST_DEPTH) - 1; k >= 0; k--) begin
            if (hist[k].valid && (hist[k].regNum == SrcRegE[i*REG_AW +: REG_AW])) begin
              SrcE[i*DATA_W +: DATA_W] = hist[k].data;
              FwdSel[i*2 +: 2]         = 2'b11;
            end
          end
        end
      end
    end
  end

  // Load in E whose destination is read by the instruction in D
  always_comb begin
    loadUseHazard = 1'b0;
    if (RegWriteE && MemToRegE && (WriteRegE != '0)) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (SrcUsedD[i] && (SrcRegD[i*REG_AW +: REG_AW] == WriteRegE)) begin
          loadUseHazard = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (loadUseHazard) stateNext = BUBBLE;
      BUBBLE:  stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushE = 1'b0;
    if (!Reset && (state == RUN) && loadUseHazard) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != {CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a time-indexed log of W-stage writes
// predicts forwarding and stalls every cycle, with literal spot checks.
module tb_fwd_hazard_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned HD = 2;
  localparam int unsigned CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NS*AW-1:0]  SrcRegE, SrcRegD;
  logic [NS*DW-1:0]  ReadSrcE, SrcE;
  logic [NS-1:0]     SrcUsedD;
  logic              RegWriteE, MemToRegE, RegWriteM, RegWriteW;
  logic [AW-1:0]     WriteRegE, WriteRegM, WriteRegW;
  logic [DW-1:0]     ALUOutM, ResultW;
  logic [NS*2-1:0]   FwdSel;
  logic              StallF, StallD, FlushE;
  logic [CW-1:0]     StallCnt;

  int nChecks = 0;
  int nFails  = 0;

  fwd_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .HIST_DEPTH(HD), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .SrcRegE(SrcRegE), .ReadSrcE(ReadSrcE), .SrcRegD(SrcRegD), .SrcUsedD(SrcUsedD),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .SrcE(SrcE), .FwdSel(FwdSel),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallCnt(StallCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: every W write is logged by the clock edge that retires it; an entry
  // is visible for HD cycles unless a reset edge came after it.
  typedef struct packed {
    logic          v;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wRec_t;

  wRec_t wLog [int];
  int    edgeNo        = 0;
  int    lastResetEdge = 0;
  bit    prevStall     = 1'b0;
  int    cntModel      = 0;

  function automatic bit hazardNow();
    if (Reset || prevStall) return 1'b0;
    if (!(RegWriteE && MemToRegE && (WriteRegE != '0))) return 1'b0;
    for (int i = 0; i < int'(NS); i++)
      if (SrcUsedD[i] && (SrcRegD[i*AW +: AW] == WriteRegE)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void expFwd(input int i, output logic [DW-1:0] d, output logic [1:0] s);
    logic [AW-1:0] r;
    int e;
    r = SrcRegE[i*AW +: AW];
    d = ReadSrcE[i*DW +: DW];
    s = 2'b00;
    if (r == '0) return;
    if (RegWriteM && (WriteRegM == r)) begin d = ALUOutM; s = 2'b01; return; end
    if (RegWriteW && (WriteRegW == r)) begin d = ResultW; s = 2'b10; return; end
    for (int age = 1; age <= int'(HD); age++) begin
      e = edgeNo - age + 1;
      if ((e > lastResetEdge) && wLog.exists(e) && wLog[e].v && (wLog[e].r == r)) begin
        d = wLog[e].d;
        s = 2'b11;
        return;
      end
    end
  endfunction

  always @(posedge Clk) begin : model
    bit st;
    st = hazardNow();
    edgeNo++;
    if (Reset) begin
      lastResetEdge = edgeNo;
      cntModel      = 0;
      prevStall     = 1'b0;
    end else begin
      wLog[edgeNo] = '{v: RegWriteW && (WriteRegW != '0), r: WriteRegW, d: ResultW};
      if (st && (cntModel < CMAX)) cntModel++;
      prevStall = st;
    end
  end

  always @(negedge Clk) begin : compare
    logic [DW-1:0] d;
    logic [1:0]    s;
    bit            h;
    for (int i = 0; i < int'(NS); i++) begin
      expFwd(i, d, s);
      check($sformatf("SrcE[%0d]", i), 64'(SrcE[i*DW +: DW]), 64'(d));
      check($sformatf("FwdSel[%0d]", i), 64'(FwdSel[i*2 +: 2]), 64'(s));
    end
    h = hazardNow();
    check("StallF", 64'(StallF), 64'(h));
    check("StallD", 64'(StallD), 64'(h));
    check("FlushE", 64'(FlushE), 64'(h));
    check("StallCnt", 64'(StallCnt), 64'(cntModel));
  end

  task automatic clearIns();
    SrcRegE = '0; ReadSrcE = '0; SrcRegD = '0; SrcUsedD = '0;
    RegWriteE = 1'b0; MemToRegE = 1'b0; WriteRegE = '0;
    RegWriteM = 1'b0; WriteRegM = '0; ALUOutM = '0;
    RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
    clearIns();
  endtask

  task automatic loadE(input logic [AW-1:0] r);
    RegWriteE = 1'b1; MemToRegE = 1'b1; WriteRegE = r;
  endtask

  task automatic useD(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [1:0] used);
    SrcRegD = {r1, r0}; SrcUsedD = used;
  endtask

  task automatic srcE(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                      input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    SrcRegE = {r1, r0}; ReadSrcE = {v1, v0};
  endtask

  task automatic wrM(input logic [AW-1:0] r, input logic [DW-1:0] v);
    RegWriteM = 1'b1; WriteRegM = r; ALUOutM = v;
  endtask

  task automatic wrW(input logic [AW-1:0] r, input logic [DW-1:0] v);
    RegWriteW = 1'b1; WriteRegW = r; ResultW = v;
  endtask

  initial begin
    Reset = 1'b1;
    clearIns();
    // Hazard present while in reset: no stall
    nextCycle(); loadE(5'd6); useD(5'd6, 5'd6, 2'b11);
    #2 check("lit_rst_stall", 64'(StallD), 64'd0);
    check("lit_rst_cnt", 64'(StallCnt), 64'd0);
    nextCycle(); Reset = 1'b0;
    // add $3 then sub $4,$3,$5
    srcE(5'd3, 5'd5, 32'h0, 32'h55); wrM(5'd3, 32'h10);
    #2 check("lit_fwdM_data", 64'(SrcE[31:0]), 64'h10);
    check("lit_fwdM_sel", 64'(FwdSel), 64'b0001);
    check("lit_fwdM_src1", 64'(SrcE[63:32]), 64'h55);
    check("lit_fwdM_nostall", 64'(StallD), 64'd0);
    nextCycle(); srcE(5'd3, 5'd0, 32'h0, 32'h0); wrW(5'd3, 32'hDEAD_BEEF);
    #2 check("lit_fwdW_data", 64'(SrcE[31:0]), 64'hDEAD_BEEF);
    check("lit_fwdW_sel", 64'(FwdSel[1:0]), 64'b10);
    nextCycle(); srcE(5'd3, 5'd0, 32'h0, 32'h0); wrW(5'd3, 32'hDEAD_BEEF); wrM(5'd3, 32'h1);
    #2 check("lit_MoverW_data", 64'(SrcE[31:0]), 64'h1);
    check("lit_MoverW_sel", 64'(FwdSel[1:0]), 64'b01);
    // lw $6 then and $7,$6,$6
    nextCycle(); loadE(5'd6); useD(5'd6, 5'd6, 2'b11);
    #2 check("lit_lu_stallF", 64'(StallF), 64'd1);
    check("lit_lu_flushE", 64'(FlushE), 64'd1);
    check("lit_lu_cnt0", 64'(StallCnt), 64'd0);
    nextCycle(); loadE(5'd6); useD(5'd6, 5'd6, 2'b11); wrM(5'd6, 32'h0);
    #2 check("lit_bubble_masked", 64'(StallD), 64'd0);
    check("lit_lu_cnt1", 64'(StallCnt), 64'd1);
    nextCycle(); srcE(5'd6, 5'd6, 32'h0, 32'h0); wrW(5'd6, 32'h1234_5678);
    #2 check("lit_lu_fwd", 64'(SrcE), {32'h1234_5678, 32'h1234_5678});
    check("lit_lu_sel", 64'(FwdSel), 64'b1010);
    // History: $8 retired, visible for HD cycles then gone
    nextCycle(); wrW(5'd8, 32'hCAFE_0001);
    nextCycle(); srcE(5'd8, 5'd0, 32'h0, 32'h0);
    #2 check("lit_hist_data", 64'(SrcE[31:0]), 64'hCAFE_0001);
    check("lit_hist_sel", 64'(FwdSel[1:0]), 64'b11);
    nextCycle(); srcE(5'd8, 5'd0, 32'h0, 32'h0);
    nextCycle(); srcE(5'd8, 5'd0, 32'h0, 32'h0);
    #2 check("lit_hist_aged", 64'(FwdSel[1:0]), 64'b00);
    // Two history hits: younger wins; then W beats history
    nextCycle(); wrW(5'd9, 32'hA);
    nextCycle(); wrW(5'd9, 32'hB);
    nextCycle(); srcE(5'd9, 5'd0, 32'h0, 32'h0);
    #2 check("lit_hist_young", 64'(SrcE[31:0]), 64'hB);
    nextCycle(); srcE(5'd9, 5'd0, 32'h0, 32'h0); wrW(5'd9, 32'hC);
    #2 check("lit_W_over_hist", 64'(SrcE[31:0]), 64'hC);
    // Register 0: never forwarded, load to $0 never stalls
    nextCycle(); srcE(5'd0, 5'd0, 32'h0, 32'h0); wrM(5'd0, 32'hFFFF_FFFF); wrW(5'd0, 32'h77);
    loadE(5'd0); useD(5'd0, 5'd0, 2'b11);
    #2 check("lit_r0_data", 64'(SrcE[31:0]), 64'h0);
    check("lit_r0_sel", 64'(FwdSel), 64'b0000);
    check("lit_r0_nostall", 64'(StallD), 64'd0);
    // Unused source does not stall
    nextCycle(); loadE(5'd10); useD(5'd10, 5'd10, 2'b00);
    #2 check("lit_unused_nostall", 64'(StallD), 64'd0);
    // Back-to-back loads; counter saturates at 3
    nextCycle(); loadE(5'd10); useD(5'd0, 5'd10, 2'b10);
    nextCycle(); loadE(5'd10); useD(5'd0, 5'd10, 2'b10);
    nextCycle(); loadE(5'd11); useD(5'd11, 5'd0, 2'b01);
    #2 check("lit_b2b_stall", 64'(StallD), 64'd1);
    nextCycle();
    nextCycle(); loadE(5'd12); useD(5'd12, 5'd12, 2'b11);
    nextCycle();
    #2 check("lit_cnt_sat_a", 64'(StallCnt), 64'd3);
    nextCycle(); loadE(5'd13); useD(5'd13, 5'd0, 2'b01);
    nextCycle();
    #2 check("lit_cnt_sat_b", 64'(StallCnt), 64'd3);
    // Reset during BUBBLE
    nextCycle(); loadE(5'd14); useD(5'd14, 5'd14, 2'b11); wrW(5'd12, 32'h42);
    nextCycle(); Reset = 1'b1; loadE(5'd14); useD(5'd14, 5'd14, 2'b11); srcE(5'd12, 5'd0, 32'h0, 32'h0);
    #2 check("lit_rstbub_stall", 64'(StallF), 64'd0);
    check("lit_rstbub_fwd", 64'(SrcE[31:0]), 64'h42);
    nextCycle(); Reset = 1'b0; loadE(5'd14); useD(5'd14, 5'd14, 2'b11); srcE(5'd12, 5'd0, 32'h0, 32'h0);
    #2 check("lit_rst_cnt_clr", 64'(StallCnt), 64'd0);
    check("lit_rst_hist_clr", 64'(FwdSel[1:0]), 64'b00);
    check("lit_rst_run", 64'(StallD), 64'd1);
    nextCycle();
    #2 check("lit_rst_cnt_inc", 64'(StallCnt), 64'd1);
    nextCycle();
    nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
